// File: rtl/ssp_apb_sequencer.sv
// APB master that configures a PL022-style SSP, streams a fixed-length job of
// TX words through DR while collecting RX words, then disables the port.
module ssp_apb_sequencer (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        start,
    input  logic [15:0] cfg_cr0,
    input  logic [7:0]  cfg_cpsr,
    input  logic [7:0]  len,
    input  logic [15:0] tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [15:0] rx_data,
    output logic        rx_valid,
    output logic        busy,
    output logic        done,
    output logic [11:2] PADDR,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [15:0] PWDATA,
    input  logic [15:0] PRDATA
);

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 10;
    localparam int unsigned CW = 9;

    localparam logic [AW-1:0] A_CR0  = AW'(0);
    localparam logic [AW-1:0] A_CR1  = AW'(1);
    localparam logic [AW-1:0] A_DR   = AW'(2);
    localparam logic [AW-1:0] A_SR   = AW'(3);
    localparam logic [AW-1:0] A_CPSR = AW'(4);

    localparam int unsigned SR_TFE = 0;
    localparam int unsigned SR_TNF = 1;
    localparam int unsigned SR_RNE = 2;
    localparam int unsigned SR_BSY = 4;

    typedef enum logic [3:0] {
        IDLE, CR1_OFF, CR0, CPSR, CR1_ON, POLL, RD_DR, WR_DR, CR1_END, DONE
    } state_t;

    state_t        state;
    state_t        nxt;
    logic [DW-1:0] cr0_q;
    logic [7:0]    cpsr_q;
    logic [7:0]    len_q;
    logic [CW-1:0] len_w;
    logic [CW-1:0] tx_cnt;
    logic [CW-1:0] rx_cnt;
    logic [AW-1:0] nxt_addr;
    logic          nxt_write;
    logic [DW-1:0] nxt_wdata;

    assign len_w = CW'(len_q);

    // Successor of the current access state, decided at the end of its ACCESS
    // phase (PRDATA is the SR value captured on that edge while polling).
    always_comb begin
        nxt       = IDLE;
        nxt_addr  = A_CR0;
        nxt_write = 1'b0;
        nxt_wdata = '0;
        case (state)
            CR1_OFF: nxt = CR0;
            CR0:     nxt = CPSR;
            CPSR:    nxt = CR1_ON;
            CR1_ON:  nxt = POLL;
            POLL: begin
                if (PRDATA[SR_RNE] && (rx_cnt < len_w))
                    nxt = RD_DR;
                else if (PRDATA[SR_TNF] && (tx_cnt < len_w) && tx_valid)
                    nxt = WR_DR;
                else if ((tx_cnt == len_w) && (rx_cnt == len_w) &&
                         !PRDATA[SR_BSY] && PRDATA[SR_TFE])
                    nxt = CR1_END;
                else
                    nxt = POLL;
            end
            RD_DR:   nxt = POLL;
            WR_DR:   nxt = POLL;
            CR1_END: nxt = DONE;
            default: nxt = IDLE;
        endcase

        case (nxt)
            CR0:     begin nxt_addr = A_CR0;  nxt_write = 1'b1; nxt_wdata = cr0_q;            end
            CPSR:    begin nxt_addr = A_CPSR; nxt_write = 1'b1; nxt_wdata = {8'h00, cpsr_q};  end
            CR1_ON:  begin nxt_addr = A_CR1;  nxt_write = 1'b1; nxt_wdata = DW'(16'h0002);    end
            POLL:    begin nxt_addr = A_SR;   nxt_write = 1'b0;                               end
            RD_DR:   begin nxt_addr = A_DR;   nxt_write = 1'b0;                               end
            WR_DR:   begin nxt_addr = A_DR;   nxt_write = 1'b1; nxt_wdata = tx_data;          end
            CR1_END: begin nxt_addr = A_CR1;  nxt_write = 1'b1;                               end
            default: begin nxt_addr = A_CR0;  nxt_write = 1'b0;                               end
        endcase
    end

    // Sequencer: each access state spends one SETUP and one ACCESS cycle; the
    // next SETUP is launched on the same edge that ends the ACCESS.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state    <= IDLE;
            cr0_q    <= '0;
            cpsr_q   <= '0;
            len_q    <= '0;
            tx_cnt   <= '0;
            rx_cnt   <= '0;
            PSEL     <= 1'b0;
            PENABLE  <= 1'b0;
            PWRITE   <= 1'b0;
            PADDR    <= '0;
            PWDATA   <= '0;
            tx_ready <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            done     <= 1'b0;
            tx_ready <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        if (len != 8'd0) begin
                            cr0_q   <= cfg_cr0;
                            cpsr_q  <= cfg_cpsr;
                            len_q   <= len;
                            tx_cnt  <= '0;
                            rx_cnt  <= '0;
                            state   <= CR1_OFF;
                            PSEL    <= 1'b1;
                            PENABLE <= 1'b0;
                            PADDR   <= A_CR1;
                            PWRITE  <= 1'b1;
                            PWDATA  <= '0;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    if (!PENABLE) begin
                        PENABLE  <= 1'b1;
                        tx_ready <= (state == WR_DR);
                    end else begin
                        if (state == RD_DR) begin
                            rx_data  <= PRDATA;
                            rx_valid <= 1'b1;
                            rx_cnt   <= rx_cnt + CW'(1);
                        end
                        if (state == WR_DR)
                            tx_cnt <= tx_cnt + CW'(1);
                        state   <= nxt;
                        PENABLE <= 1'b0;
                        if (nxt == DONE) begin
                            PSEL   <= 1'b0;
                            PADDR  <= '0;
                            PWRITE <= 1'b0;
                            PWDATA <= '0;
                            done   <= 1'b1;
                        end else begin
                            PSEL   <= 1'b1;
                            PADDR  <= nxt_addr;
                            PWRITE <= nxt_write;
                            PWDATA <= nxt_wdata;
                        end
                    end
                end
            endcase
        end
    end

endmodule
